uart_fifo_rx: RTL and testbench

UART_FIFO_RX -- requirements
Module: uart_fifo_rx

---
 rtl/uart_fifo_rx.sv | 84 ++++++++
 tb/tb_uart_fifo_rx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_rx.sv
// UART receive FIFO: edge-detected push/pop, first-word fall-through read.
// Overrun pulses one cycle when a byte arrives while the FIFO is full.
module uart_fifo_rx #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] d_out,
  input  logic                 rx_done,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 rx_empty,
  output logic                 rx_full,
  output logic                 overrun
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = ADDR_BITS + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 rx_done_q, rd_q;
  logic                 overrun_q, overrun_d;

  logic push_req, pop_req;
  logic do_push, do_pop;
  logic empty, full;

  assign push_req = rx_done & ~rx_done_q;
  assign pop_req  = rd & ~rd_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_pop  = pop_req & ~empty;
  assign do_push = push_req & (~full | do_pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = push_req & full & ~pop_req;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      rx_done_q <= 1'b1;
      rd_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      rx_done_q <= rx_done;
      rd_q      <= rd;
    end
  end

  // Storage is left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= d_out;
  end

  assign r_data   = mem_q[rd_ptr_q];
  assign rx_empty = empty;
  assign rx_full  = full;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_fifo_rx.sv
// Directed bench for uart_fifo_rx with a queue scoreboard of expected bytes.
module tb_uart_fifo_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d_out;
  logic       rx_done;
  logic       rd;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rx_full;
  logic       overrun;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  uart_fifo_rx #(.DATA_BITS(8), .ADDR_BITS(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .d_out    (d_out),
    .rx_done  (rx_done),
    .rd       (rd),
    .r_data   (r_data),
    .rx_empty (rx_empty),
    .rx_full  (rx_full),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag);
    chk({tag, " empty"}, 32'(rx_empty), 32'(sb.size() == 0));
    chk({tag, " full"},  32'(rx_full),  32'(sb.size() == 4));
    if (sb.size() != 0) chk({tag, " head"}, 32'(r_data), 32'(sb[0]));
  endtask

  // Raise rx_done for 'hold' cycles; check overrun on the cycle after the edge.
  task automatic push(input logic [7:0] b, input int hold);
    logic ov;
    ov = (sb.size() == 4);
    d_out   = b;
    rx_done = 1'b1;
    if (!ov) sb.push_back(b);
    @(negedge clk);
    chk("overrun_pulse", 32'(overrun), 32'(ov));
    flags("push");
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("overrun_hold", 32'(overrun), 32'h0);
      flags("push_hold");
    end
    rx_done = 1'b0;
    @(negedge clk);
    chk("overrun_after", 32'(overrun), 32'h0);
  endtask

  task automatic pop(input int hold);
    rd = 1'b1;
    if (sb.size() != 0) void'(sb.pop_front());
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      flags("pop");
    end
    rd = 1'b0;
    @(negedge clk);
    flags("pop_after");
  endtask

  initial begin
    reset = 1'b1; rx_done = 1'b0; rd = 1'b0; d_out = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_empty",   32'(rx_empty), 32'h1);
    chk("rst_full",    32'(rx_full),  32'h0);
    chk("rst_overrun", 32'(overrun),  32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Held level pushes exactly once
    push(8'd50, 5);
    chk("held_r_data", 32'(r_data), 32'd50);
    pop(1);
    chk("held_single", 32'(rx_empty), 32'h1);

    // Fill, overrun, drain with a long rd level
    push(8'd10, 1); push(8'd20, 1); push(8'd30, 1); push(8'd40, 1);
    chk("fill_full", 32'(rx_full), 32'h1);
    push(8'd99, 1);
    pop(3); pop(1); pop(1); pop(1);
    chk("drain_empty", 32'(rx_empty), 32'h1);

    // Pop on empty is ignored
    pop(1);
    push(8'd7, 1);
    chk("after_empty_pop", 32'(r_data), 32'd7);
    pop(1);

    // Full with simultaneous push/pop
    push(8'd1, 1); push(8'd2, 1); push(8'd3, 1); push(8'd4, 1);
    d_out = 8'd5; rx_done = 1'b1; rd = 1'b1;
    void'(sb.pop_front()); sb.push_back(8'd5);
    @(negedge clk);
    chk("simul_overrun", 32'(overrun), 32'h0);
    chk("simul_full",    32'(rx_full), 32'h1);
    chk("simul_head",    32'(r_data),  32'd2);
    rx_done = 1'b0; rd = 1'b0;
    @(negedge clk);
    chk("simul_ov_after", 32'(overrun), 32'h0);
    pop(1); pop(1); pop(1); pop(1);

    // Empty with simultaneous push/pop: push only
    d_out = 8'hC3; rx_done = 1'b1; rd = 1'b1;
    sb.push_back(8'hC3);
    @(negedge clk);
    flags("empty_simul");
    rx_done = 1'b0; rd = 1'b0;
    @(negedge clk);
    pop(1);

    // Pointer wrap
    for (int k = 1; k <= 6; k++) begin
      push(8'(k * 8'h11), 1);
      pop(1);
    end

    // Mid-operation reset with rx_done held
    push(8'hA1, 1);
    d_out = 8'hA2; rx_done = 1'b1; sb.push_back(8'hA2);
    @(negedge clk);
    flags("pre_reset");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("mid_rst_empty", 32'(rx_empty), 32'h1);
    chk("mid_rst_full",  32'(rx_full),  32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("held_after_rst", 32'(rx_empty), 32'h1);
    end
    rx_done = 1'b0;
    @(negedge clk);
    push(8'h3C, 1);
    chk("post_rst_push", 32'(r_data), 32'h3C);
    pop(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
